// File: rtl/tx_buffer.sv
// Circular FIFO between the interface controller and uart_tx. Drains one byte
// per frame: 1-cycle tx_start, wait for tx_done_tick, then a guard gap.
module tx_buffer #(
   parameter int NB_DATA    = 8,
   parameter int ADDR_W     = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic [NB_DATA-1:0] w_data,
   input  logic               tx_done_tick,
   output logic               tx_start,
   output logic [NB_DATA-1:0] tx_data,
   output logic               full,
   output logic               empty,
   output logic [ADDR_W:0]    count,
   output logic               busy,
   output logic               overflow
);

   // state     | meaning
   // IDLE      | waiting for a buffered byte; pops it and raises tx_start
   // START     | tx_start high for this single cycle
   // WAIT_DONE | frame on the wire, tx_data held, waiting for tx_done_tick
   // GAP       | guard gap countdown before the next byte
   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

   localparam int DEPTH    = 2**ADDR_W;
   localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   logic [NB_DATA-1:0] mem_q [DEPTH];

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               overflow_q, overflow_d;
   logic               tx_start_q, tx_start_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               pop;
   logic               push;

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      gap_d      = gap_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_q) begin
               pop        = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q];
               rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
               tx_start_d = 1'b1;
               state_d    = START;
            end
         end
         START: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (tx_done_tick) begin
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  gap_d   = GAP_W'(GAP_LOAD);
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop in the same cycle frees a slot, so a push at full is still accepted.
   always_comb begin
      push       = wr && (!full_q || pop);
      overflow_d = overflow_q | (wr & ~push);
      wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      count_d    = count_q;
      if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);
      full_d     = (count_d == (ADDR_W+1)'(DEPTH));
      empty_d    = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= w_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         gap_q      <= gap_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;

endmodule
